// File: rtl/nios2_jtag_scan_master_if.sv
// Scan command / response bundle for nios2_jtag_scan_master.
//   master : side that issues scan commands and consumes responses
//   slave  : the scan master itself (accepts commands, returns captured TDO)
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_is_ir            1 = IR scan, 0 = DR scan
//   cmd_len              number of bits to shift
//   cmd_data             TDI bits, bit 0 shifted first
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             captured TDO, bit i = i-th shifted bit
interface nios2_jtag_scan_master_if #(
   parameter int MAX_LEN = 38,
   parameter int LEN_W   = 6
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_is_ir;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_is_ir, cmd_len, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_is_ir, cmd_len, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/nios2_jtag_scan_master.sv
// Host-side JTAG initiator. Accepts IR/DR scan commands, walks the TAP
// state machine over tck/tms/tdi, shifts data LSB-first and returns the
// captured TDO bits.
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   bus (slave)       command/response handshake bundle
//   busy              high in every state except IDLE
//   tck, tms, tdi     JTAG outputs to the target
//   tdo               JTAG input from the target (registered once)
//   trst_n            TAP reset, present only with NIOS2_JTAG_SCAN_TRST_EN
// Optional feature macro: NIOS2_JTAG_SCAN_TRST_EN adds trst_n, held low
// during reset and for 4 TCK periods after, before the INIT TMS sequence.
module nios2_jtag_scan_master #(
   parameter int MAX_LEN = 38,
   parameter int TCK_DIV = 4,
   parameter int LEN_W   = 6
) (
   input  logic                      clk,
   input  logic                      reset_n,
   nios2_jtag_scan_master_if.slave   bus,
   output logic                      busy,
   output logic                      tck,
   output logic                      tms,
   output logic                      tdi,
   input  logic                      tdo
`ifdef NIOS2_JTAG_SCAN_TRST_EN
   ,
   output logic                      trst_n
`endif
);

   localparam int DIV_W = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;

   typedef enum logic [3:0] {
      ST_TRST, ST_INIT, ST_IDLE, ST_SEL, ST_CAPTURE,
      ST_SHIFT_ENTRY, ST_SHIFT, ST_UPDATE, ST_RTI, ST_RESP
   } state_e;

`ifdef NIOS2_JTAG_SCAN_TRST_EN
   localparam state_e RESET_ST = ST_TRST;
   logic trst_n_q, trst_n_d;
`else
   localparam state_e RESET_ST = ST_INIT;
`endif

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;     // step index inside the current state
   logic [DIV_W-1:0]   div_q, div_d;     // clk cycles elapsed in the current TCK phase
   logic               tck_q, tck_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               tdo_q;
   logic               is_ir_q, is_ir_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [MAX_LEN-1:0] data_q, data_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               busy_q, busy_d;

   // Next-state, TCK phase and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      is_ir_d     = is_ir_q;
      len_d       = len_q;
      data_d      = data_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               is_ir_d    = bus.cmd_is_ir;
               data_d     = bus.cmd_data;
               rsp_data_d = '0;
               len_d      = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;
               if (bus.cmd_len == '0) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
               end else begin
                  // First period (Select-DR) is driven straight from the accept edge.
                  state_d = ST_SEL;
                  cnt_d   = '0;
                  div_d   = '0;
                  tck_d   = 1'b0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready && rsp_valid_q) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_TRST, ST_INIT, ST_SEL, ST_CAPTURE, ST_SHIFT_ENTRY,
         ST_SHIFT, ST_UPDATE, ST_RTI: begin
            if (div_q == DIV_W'(TCK_DIV - 1)) begin
               div_d = '0;
               tck_d = ~tck_q;
               if (!tck_q) begin
                  // Rising TCK edge: capture TDO of the current shift bit.
                  if (state_q == ST_SHIFT) begin
                     rsp_data_d[cnt_q] = tdo_q;
                  end else begin
                     rsp_data_d = rsp_data_q;
                  end
               end else begin
                  // Falling TCK edge: the period ends; set up tms/tdi of the next one.
                  case (state_q)
                     ST_TRST: begin
                        tms_d = 1'b1;
                        if (cnt_q == LEN_W'(3)) begin
                           state_d = ST_INIT;
                           cnt_d   = '0;
                        end else begin
                           cnt_d = cnt_q + LEN_W'(1);
                        end
                     end
                     ST_INIT: begin
                        if (cnt_q == LEN_W'(5)) begin
                           state_d = ST_IDLE;
                           tms_d   = 1'b0;
                        end else begin
                           cnt_d = cnt_q + LEN_W'(1);
                           tms_d = (cnt_q != LEN_W'(4));
                        end
                     end
                     ST_SEL: begin
                        if (is_ir_q && (cnt_q == '0)) begin
                           cnt_d = LEN_W'(1);
                           tms_d = 1'b1;
                        end else begin
                           state_d = ST_CAPTURE;
                           tms_d   = 1'b0;
                        end
                     end
                     ST_CAPTURE: begin
                        state_d = ST_SHIFT_ENTRY;
                        tms_d   = 1'b0;
                     end
                     ST_SHIFT_ENTRY: begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                        tdi_d   = data_q[0];
                        tms_d   = (len_q == LEN_W'(1));
                     end
                     ST_SHIFT: begin
                        if (cnt_q == len_q - LEN_W'(1)) begin
                           state_d = ST_UPDATE;
                           tms_d   = 1'b1;
                           tdi_d   = 1'b0;
                        end else begin
                           cnt_d = cnt_q + LEN_W'(1);
                           tdi_d = data_q[cnt_q + LEN_W'(1)];
                           tms_d = ((cnt_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
                        end
                     end
                     ST_UPDATE: begin
                        state_d = ST_RTI;
                        tms_d   = 1'b0;
                     end
                     ST_RTI: begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        tms_d       = 1'b0;
                     end
                     default: begin
                        state_d = RESET_ST;
                     end
                  endcase
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = RESET_ST;
            cnt_d   = '0;
            div_d   = '0;
            tck_d   = 1'b0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
         end
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
`ifdef NIOS2_JTAG_SCAN_TRST_EN
      trst_n_d    = (state_d != ST_TRST);
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= RESET_ST;
         cnt_q       <= '0;
         div_q       <= '0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         tdo_q       <= 1'b0;
         is_ir_q     <= 1'b0;
         len_q       <= '0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b1;
`ifdef NIOS2_JTAG_SCAN_TRST_EN
         trst_n_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         tdo_q       <= tdo;
         is_ir_q     <= is_ir_d;
         len_q       <= len_d;
         data_q      <= data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
`ifdef NIOS2_JTAG_SCAN_TRST_EN
         trst_n_q    <= trst_n_d;
`endif
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = busy_q;
   assign tck           = tck_q;
   assign tms           = tms_q;
   assign tdi           = tdi_q;
`ifdef NIOS2_JTAG_SCAN_TRST_EN
   assign trst_n        = trst_n_q;
`endif

endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// Directed bench for nios2_jtag_scan_master. A behavioural model turns each
// command into the list of (tms, tdi) values expected at every TCK rising
// edge and the response word; one compare process checks the pins each cycle.
module tb_nios2_jtag_scan_master;
   localparam int MAX_LEN = 38;
   localparam int TCK_DIV = 4;
   localparam int LEN_W   = 6;
`ifdef NIOS2_JTAG_SCAN_TRST_EN
   localparam int INIT_ONES = 9;
`else
   localparam int INIT_ONES = 5;
`endif
   localparam int INIT_CYC = (INIT_ONES + 1) * 2 * TCK_DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic busy, tck, tms, tdi, tdo;
   logic tdo_tie1 = 1'b0;
   logic tap_cap = 1'b0;
   logic tap_out = 1'b0;
`ifdef NIOS2_JTAG_SCAN_TRST_EN
   logic trst_n;
`endif

   nios2_jtag_scan_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

   nios2_jtag_scan_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy),
      .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef NIOS2_JTAG_SCAN_TRST_EN
      , .trst_n(trst_n)
`endif
   );

   always #5 clk = ~clk;

   // Target model: one-bit register between tdi and tdo, JTAG edge rules.
   always @(posedge tck) tap_cap <= tdi;
   always @(negedge tck) tap_out <= tap_cap;
   assign tdo = tdo_tie1 ? 1'b1 : tap_out;

   logic [2:0]         exp_q[$];   // {first_of_sequence, tms, tdi}
   logic [MAX_LEN-1:0] rsp_q[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   int     rise_cnt = 0;
   longint cyc = 0;
   longint last_rise = 0;
   logic   prev_tck = 1'b0;
   logic [2:0] e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic push_init();
      for (int i = 0; i < INIT_ONES; i++) exp_q.push_back({(i == 0), 1'b1, 1'b0});
      exp_q.push_back(3'b000);
   endtask

   // Behavioural scan model: returns the expected response and queues the pin sequence.
   function automatic logic [MAX_LEN-1:0] model_scan(input logic is_ir, input int len,
                                                    input logic [MAX_LEN-1:0] data, input logic tie1);
      int l;
      logic [MAX_LEN-1:0] mask;
      l = (len > MAX_LEN) ? MAX_LEN : len;
      mask = '0;
      for (int i = 0; i < l; i++) mask[i] = 1'b1;
      if (l == 0) return '0;
      exp_q.push_back(3'b110);
      if (is_ir) exp_q.push_back(3'b010);
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b000);
      for (int k = 0; k < l; k++) exp_q.push_back({1'b0, (k == l - 1), data[k]});
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b000);
      // Target returns the bit shifted in one period earlier; bit 0 sees the entry period's 0.
      return tie1 ? mask : ((data << 1) & mask);
   endfunction

   // Compare process: pins at every TCK rise, handshake invariants every cycle.
   always @(negedge clk) begin
      cyc++;
      if (tck && !prev_tck) begin
         rise_cnt++;
         if (exp_q.size() == 0) begin
            fail_now("unexpected_tck_rise");
         end else begin
            e = exp_q.pop_front();
            check("tms", {63'd0, tms}, {63'd0, e[1]});
            check("tdi", {63'd0, tdi}, {63'd0, e[0]});
            if (!e[2]) check("tck_period", cyc - last_rise, 64'(2 * TCK_DIV));
         end
         last_rise = cyc;
      end
      prev_tck = tck;
      check("ready_vs_busy", {63'd0, bus.cmd_ready}, {63'd0, ~busy});
      if (bus.cmd_ready || bus.rsp_valid) check("tck_parked", {63'd0, tck}, 64'd0);
      if (bus.rsp_valid && bus.rsp_ready) begin
         if (rsp_q.size() == 0) fail_now("unexpected_rsp");
         else check("rsp_data", 64'(bus.rsp_data), 64'(rsp_q.pop_front()));
      end
   end

   task automatic check_reset_state();
      check("rst_tck", {63'd0, tck}, 64'd0);
      check("rst_tms", {63'd0, tms}, 64'd1);
      check("rst_tdi", {63'd0, tdi}, 64'd0);
      check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd1);
   endtask

   // Releases reset and measures clk edges until the scan master reports idle.
   task automatic release_and_time_init();
      int n;
      push_init();
      reset_n = 1'b1;
      n = 0;
      while (n < 400) begin
         @(posedge clk); #1;
         n++;
         if (bus.cmd_ready) break;
      end
      check("init_cycles", 64'(n), 64'(INIT_CYC));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!bus.cmd_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.cmd_ready) fail_now("wait_idle_timeout");
   endtask

   task automatic send(input logic is_ir, input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] data);
      wait_idle();
      rsp_q.push_back(model_scan(is_ir, int'(len), data, tdo_tie1));
      bus.cmd_valid = 1'b1;
      bus.cmd_is_ir = is_ir;
      bus.cmd_len   = len;
      bus.cmd_data  = data;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int r0;
      int n;
      logic [MAX_LEN-1:0] m;
      bus.cmd_valid = 1'b0;
      bus.cmd_is_ir = 1'b0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      release_and_time_init();

      // Hand-computed pins for the model itself.
      m = model_scan(1'b0, 38, 38'h2A_5555_AAAA, 1'b0);
      check("model_dr38", 64'(m), 64'h14_AAAB_5554);
      m = model_scan(1'b1, 2, 38'h2, 1'b1);
      check("model_ir2", 64'(m), 64'h3);
      exp_q.delete();

      // DR scan, full length, looped tdo.
      r0 = rise_cnt;
      send(1'b0, 6'd38, 38'h2A_5555_AAAA);
      wait_idle();
      check("dr38_periods", 64'(rise_cnt - r0), 64'd43);

      // IR scan, two bits, tdo tied high.
      tdo_tie1 = 1'b1;
      r0 = rise_cnt;
      send(1'b1, 6'd2, 38'h2);
      wait_idle();
      check("ir2_periods", 64'(rise_cnt - r0), 64'd8);
      tdo_tie1 = 1'b0;

      // Zero length: immediate response, no TCK activity.
      r0 = rise_cnt;
      send(1'b0, 6'd0, 38'h3F_0000_0001);
      check("len0_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("len0_rsp_data", 64'(bus.rsp_data), 64'd0);
      wait_idle();
      check("len0_periods", 64'(rise_cnt - r0), 64'd0);

      // Length above MAX_LEN clamps to 38 shift periods.
      r0 = rise_cnt;
      send(1'b0, 6'd50, 38'h3F_FFFF_FFFF);
      wait_idle();
      check("len50_periods", 64'(rise_cnt - r0), 64'd43);

      // Response back-pressure: response held stable, no new command.
      bus.rsp_ready = 1'b0;
      send(1'b0, 6'd4, 38'hB);
      n = 0;
      while (!bus.rsp_valid && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 20; i++) begin
         check("stall_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
         check("stall_rsp_data", 64'(bus.rsp_data), 64'h6);
         check("stall_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      wait_idle();

      // Reset during shift bit 10 discards the command and reruns INIT.
      r0 = rise_cnt;
      send(1'b0, 6'd20, 38'h5_A5A5);
      n = 0;
      while ((rise_cnt - r0) < 14 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("midreset_reached_bit10", 64'(rise_cnt - r0), 64'd14);
      reset_n = 1'b0;
      exp_q.delete();
      rsp_q.delete();
      @(posedge clk); #1;
      check_reset_state();
      release_and_time_init();

      // One more scan after the recovery.
      send(1'b0, 6'd3, 38'h5);
      wait_idle();

      check("exp_drained", 64'(exp_q.size()), 64'd0);
      check("rsp_drained", 64'(rsp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout (t=%0t)", $time);
      $fatal(1, "watchdog");
   end
endmodule
